// File: rtl/hsfir_decim2_buf.sv
// Half-band filter output stage: drops the filter warm-up samples, decimates 2:1 on input
// strobes, and buffers the kept samples in a first-word-fall-through FIFO with valid/ready drain.
module hsfir_decim2_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FLUSH_CNT  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          phase_sel,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (FLUSH_CNT > 0) ? $clog2(FLUSH_CNT + 1) : 1;
  localparam int unsigned FlushLastInt = (FLUSH_CNT > 0) ? FLUSH_CNT - 1 : 0;
  localparam logic [CW-1:0] FlushLast = CW'(FlushLastInt);
  localparam logic [AW:0]   Depth     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StFlush, StRun} state_e;
  localparam state_e StInit = (FLUSH_CNT == 0) ? StRun : StFlush;

  state_e                state_q, state_d;
  logic [CW-1:0]         flush_cnt_q, flush_cnt_d;
  logic                  phase_q, phase_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  keep, push, pop, drop;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    phase_d     = phase_q;
    keep        = 1'b0;
    unique case (state_q)
      StFlush: begin
        if (en_in) begin
          flush_cnt_d = flush_cnt_q + CW'(1);
          if (flush_cnt_q == FlushLast) state_d = StRun;
        end
      end
      StRun: begin
        // Decimation advances on strobes only, never on idle clocks.
        if (en_in) begin
          keep    = (phase_q == phase_sel);
          phase_d = ~phase_q;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    pop      = (count_q != '0) && m_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    push     = keep && ((count_q < Depth) || pop);
    drop     = keep && !push;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + (AW + 1)'(1);
    else if (pop && !push) count_d = count_q - (AW + 1)'(1);
    ovf_d = ovf_q;
    if (drop) ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StInit;
      flush_cnt_q <= '0;
      phase_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) mem[wr_ptr_q] <= data_in;
  end

  assign m_valid    = (count_q != '0);
  assign m_data     = m_valid ? mem[rd_ptr_q] : '0;
  assign fill_level = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_hsfir_decim2_buf.sv
// Directed bench for hsfir_decim2_buf: flush, both decimation phases, sparse strobes,
// backpressure/overflow, full-FIFO pass-through and mid-run reset.
module tb_hsfir_decim2_buf;

  logic       clk = 1'b0;
  logic       reset_n, en_in, phase_sel, m_ready, clr_ovf;
  logic [7:0] data_in, m_data;
  logic       m_valid, overflow;
  logic [3:0] fill_level;
  int         errors = 0;
  int         checks = 0;

  hsfir_decim2_buf #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(8),
    .FLUSH_CNT (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_in     (en_in),
    .data_in   (data_in),
    .phase_sel (phase_sel),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .fill_level(fill_level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; en_in = 1'b0; data_in = '0; phase_sel = 1'b0; m_ready = 1'b0;
    clr_ovf = 1'b0;
    do_reset();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_fill", 32'(fill_level), 0);
    check("rst_ovf", 32'(overflow), 0);

    // 1: continuous strobes, even phase kept, consumer always ready.
    phase_sel = 1'b0; m_ready = 1'b1; en_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      data_in = 8'(k);
      step();
      check("t1_valid", 32'(m_valid), (k >= 4 && k % 2 == 0) ? 1 : 0);
      check("t1_data", 32'(m_data), (k >= 4 && k % 2 == 0) ? k : 0);
      check("t1_fill", 32'(fill_level), (k >= 4 && k % 2 == 0) ? 1 : 0);
    end

    // 2: odd phase kept, 0x80 passes untouched.
    en_in = 1'b0;
    do_reset();
    phase_sel = 1'b1; en_in = 1'b1;
    for (int k = 0; k < 14; k++) begin
      data_in = (k == 7) ? 8'h80 : 8'(k);
      step();
      check("t2_valid", 32'(m_valid), (k >= 5 && k % 2 == 1) ? 1 : 0);
      check("t2_data", 32'(m_data), (k >= 5 && k % 2 == 1) ? ((k == 7) ? 32'h80 : k) : 0);
    end

    // 3: sparse strobes 1,0,0; decimation counts strobes.
    en_in = 1'b0;
    do_reset();
    phase_sel = 1'b0;
    for (int c = 0; c < 30; c++) begin
      en_in   = (c % 3 == 0);
      data_in = 8'(c);
      step();
      check("t3_valid", 32'(m_valid), (c % 3 == 0 && c / 3 >= 4 && (c / 3) % 2 == 0) ? 1 : 0);
      check("t3_data", 32'(m_data),
            (c % 3 == 0 && c / 3 >= 4 && (c / 3) % 2 == 0) ? c : 0);
    end

    // 4: backpressure to full, one drop, drain in order, clear overflow.
    en_in = 1'b0;
    do_reset();
    m_ready = 1'b0; en_in = 1'b1;
    for (int k = 0; k < 22; k++) begin
      data_in = 8'(k);
      step();
      check("t4_fill", 32'(fill_level), (k < 4) ? 0 : ((k >= 18) ? 8 : (k - 4) / 2 + 1));
      check("t4_head", 32'(m_data), (k < 4) ? 0 : 4);
      check("t4_ovf", 32'(overflow), (k >= 20) ? 1 : 0);
    end
    en_in = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_drain_valid", 32'(m_valid), 1);
      check("t4_drain_data", 32'(m_data), 4 + 2 * i);
      step();
    end
    check("t4_empty_valid", 32'(m_valid), 0);
    check("t4_empty_fill", 32'(fill_level), 0);
    check("t4_ovf_sticky", 32'(overflow), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 0);

    // 5: phase is 0 again after 18 run strobes; fill with 100,102,...,114.
    m_ready = 1'b0; en_in = 1'b1;
    for (int j = 0; j < 16; j++) begin
      data_in = 8'(100 + j);
      step();
    end
    check("t5_full", 32'(fill_level), 8);
    check("t5_ovf0", 32'(overflow), 0);
    data_in = 8'd116; m_ready = 1'b1;
    step();
    check("t5_pushpop_fill", 32'(fill_level), 8);
    check("t5_pushpop_ovf", 32'(overflow), 0);
    check("t5_pushpop_head", 32'(m_data), 102);
    data_in = 8'd117; m_ready = 1'b0;
    step();
    data_in = 8'd118; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t5_set_wins", 32'(overflow), 1);
    check("t5_fill_after_drop", 32'(fill_level), 8);
    en_in = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t5_drain_data", 32'(m_data), 102 + 2 * i);
      step();
    end
    check("t5_empty", 32'(m_valid), 0);

    // 6: reset with five entries queued, then flush again.
    do_reset();
    m_ready = 1'b0; en_in = 1'b1;
    for (int k = 0; k < 13; k++) begin
      data_in = 8'(k);
      step();
    end
    check("t6_fill5", 32'(fill_level), 5);
    reset_n = 1'b0; data_in = 8'd13;
    step();
    reset_n = 1'b1;
    check("t6_rst_valid", 32'(m_valid), 0);
    check("t6_rst_data", 32'(m_data), 0);
    check("t6_rst_fill", 32'(fill_level), 0);
    check("t6_rst_ovf", 32'(overflow), 0);
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_in = 8'(50 + k);
      step();
      check("t6_valid", 32'(m_valid), (k == 4) ? 1 : 0);
      check("t6_data", 32'(m_data), (k == 4) ? 54 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hsfir_decim2_buf.md
Name: hsfir_decim2_buf

Overview:
- Downstream stage of the cheap half-band FIR (hsFIRcheap).
- Consumes its 8-bit filtered sample stream and discards the filter warm-up samples after reset.
- Performs 2:1 decimation with a selectable kept phase.
- Buffers kept samples in a small first-word-fall-through FIFO drained by a valid/ready consumer, so later stages can apply backpressure without stalling the free-running filter.

Parameters:
- DATA_WIDTH, 8: sample width, two's complement, passed through unmodified.
- FIFO_DEPTH, 8: FIFO entries; power of two, >= 2.
- FLUSH_CNT, 4: number of input strobes discarded after reset (filter fill latency); 0 = no flush.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en_in  in  1  input strobe; data_in valid this cycle. Tied high when hsFIRcheap runs one sample per clock.
- data_in  in  DATA_WIDTH  filtered sample (hsFIRcheap data_out).
- phase_sel  in  1  kept decimation phase: 0 = even strobes, 1 = odd strobes.
- m_valid  out  1  FIFO head valid.
- m_data  out  DATA_WIDTH  FIFO head sample; forced 0 when m_valid=0.
- m_ready  in  1  consumer accepts head this cycle.
- fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a kept sample was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - m_valid=0, m_data=0, fill_level=0, overflow=0.
  - Read/write pointers=0, phase bit=0, flush counter=0.
  - State=FLUSH (RUN if FLUSH_CNT=0).
  - Reset mid-operation discards all FIFO contents; outputs are at reset values the cycle after.
- FLUSH state:
  - Each cycle with en_in=1 increments the flush counter; the sample is discarded.
  - Phase bit held at 0.
  - When the counter reaches FLUSH_CNT-1 with en_in=1, go to RUN next cycle.
  - That strobe is the last discarded one.
- RUN state:
  - Each en_in=1 cycle: sample kept iff phase bit == phase_sel, then phase bit toggles.
  - First RUN strobe has phase 0.
  - en_in=0: phase, state and flush counter unchanged.
  - Decimation counts strobes, not clocks.
- phase_sel is sampled on every strobe. A change takes effect on the next strobe and may produce one 1-sample or 3-sample gap; no reset of phase.
- Push: a kept sample is written if fill_level < FIFO_DEPTH, or if fill_level == FIFO_DEPTH and a pop occurs the same cycle.
- Drop: if full with no pop, the sample is dropped and overflow is set.
- Pop: m_valid=1 and m_ready=1 at a rising edge; the read pointer advances.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fill_level, or from an extra pointer bit.
- FWFT timing:
  - A sample written into an empty FIFO gives m_valid=1 and m_data=sample on the cycle after the strobe (latency 1).
  - No combinational path from data_in or en_in to m_*.
- Stability: m_data is held constant while m_valid=1 and m_ready=0.
- m_ready is ignored when m_valid=0; no pop and no underflow.
- fill_level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (including when full).
- overflow: stays set until clr_ovf=1. If clr_ovf and a drop occur the same cycle, overflow=1 (set wins).
- No arithmetic on samples. DATA_WIDTH bits pass bit-exact, including -128 (0x80).

Test Plan:
1. FLUSH_CNT=4, phase_sel=0, en_in=1 continuous, data_in=0,1,2,... per cycle, m_ready=1 -> 0..3 discarded; m_data sequence 4,6,8,10...; first m_valid the cycle after data_in=4; fill_level never exceeds 1.
2. Same stimulus with phase_sel=1 -> m_data 5,7,9...; data_in=0x80 at a kept phase appears as 0x80 unchanged.
3. en_in pattern 1,0,0,1,... with data_in incrementing per clock, phase_sel=0 -> only strobed samples count; after flush every second strobed value is output; no output on en_in=0 cycles.
4. Backpressure, FIFO_DEPTH=8: m_ready=0 -> fill_level reaches 8, m_data holds 4 throughout. The 9th kept sample is dropped and overflow=1. Then m_ready=1 -> 8 values drained in order, m_valid falls after the last, overflow remains 1. clr_ovf pulse -> overflow=0.
5. Full FIFO, m_ready=1 on the same cycle as a kept strobe -> no overflow, fill_level stays 8, order preserved. clr_ovf coincident with a drop -> overflow=1.
6. fill_level=5, assert reset_n=0 for one cycle -> next cycle m_valid=0, m_data=0, fill_level=0, overflow=0. The next 4 strobes are discarded again before output resumes.
